// File: rtl/piso_arbiter_if.sv
// Requester and piso-side signal bundle for piso_arbiter.
// slave = the arbiter, master = the requesters/piso environment.
interface piso_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int GW = $clog2(NUM_REQ);

  // Handshake: a requester raises i_req_valid[k] with stable i_req_data and
  // holds both until o_req_ready[k] is seen high; that single ready cycle is
  // the transfer.
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic                          o_piso_wr_en;
  logic [DATA_WIDTH-1:0]         o_piso_data;
  logic                          i_piso_data_valid;
  logic                          o_busy;
  logic [GW-1:0]                 o_grant_id;
  logic                          o_done;
  logic                          o_err_timeout;

  modport slave (
    input  i_req_valid, i_req_data, i_piso_data_valid,
    output o_req_ready, o_piso_wr_en, o_piso_data, o_busy, o_grant_id,
           o_done, o_err_timeout
  );

  modport master (
    output i_req_valid, i_req_data, i_piso_data_valid,
    input  o_req_ready, o_piso_wr_en, o_piso_data, o_busy, o_grant_id,
           o_done, o_err_timeout
  );
endinterface

// File: rtl/piso_arbiter.sv
// Round-robin sequencer sharing one piso among NUM_REQ word requesters.
// Optional WAIT watchdog enabled by defining PISO_ARB_TIMEOUT_EN.
module piso_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             i_clk,
  input  logic             i_a_rst_n,
  piso_arbiter_if.slave    bus,
  output logic [1:0]       o_dbg_state
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_SHIFT} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [NUM_REQ-1:0]    ready_q, ready_d;
  logic                  wr_en_q, wr_en_d;
  logic                  done_q, done_d;
  logic [1:0]            rst_sync_q;
  logic                  rst_n;
  logic                  win_found;
  logic [GW-1:0]         win_idx;

`ifdef PISO_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
`else
  logic [31:0]   unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  // Assertion is immediate; release reaches the core two edges later.
  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_found && bus.i_req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = GW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    grant_d = grant_q;
    ready_d = '0;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
`ifdef PISO_ARB_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (win_found) begin
          data_d           = bus.i_req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          grant_d          = win_idx;
          ready_d[win_idx] = 1'b1;
          wr_en_d          = 1'b1;
          ptr_d            = (win_idx == GW'(NUM_REQ - 1)) ? '0 : win_idx + GW'(1);
          state_d          = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef PISO_ARB_TIMEOUT_EN
        wd_d = WW'(1);
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The first valid cycle is already bit 1 of the frame.
        if (bus.i_piso_data_valid) begin
          if (DATA_WIDTH == 1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = CW'(1);
            state_d = S_SHIFT;
          end
        end
`ifdef PISO_ARB_TIMEOUT_EN
        else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
`endif
      end
      S_SHIFT: begin
        if (bus.i_piso_data_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(DATA_WIDTH)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
      ready_q <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
`ifdef PISO_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.o_req_ready  = ready_q;
  assign bus.o_piso_wr_en = wr_en_q;
  assign bus.o_piso_data  = data_q;
  assign bus.o_busy       = (state_q != S_IDLE);
  assign bus.o_grant_id   = grant_q;
  assign bus.o_done       = done_q;
`ifdef PISO_ARB_TIMEOUT_EN
  assign bus.o_err_timeout = err_q;
`else
  assign bus.o_err_timeout = 1'b0;
`endif
  assign o_dbg_state = state_q;
endmodule
